spi_slave_regs: RTL
===================

SPI_SLAVE_REGS -- requirements
Module: spi_slave_regs

Interface
REQ-001 Clock clk, reset rst_n (asynchronous, active-low); all logic SHALL be in the clk domain.
REQ-002 Parameter: SYNC_STAGES, 2, synchronizer depth on sck/cs/mosi (legal 2..3).
REQ-003 clk  input  1  system clock; sck SHALL be at most clk/8.
REQ-004 rst_n  input  1  async active-low reset.
REQ-005 sck  input  1  SPI clock from master, idle level don't-care.
REQ-006 cs  input  1  active-low chip select.
REQ-007 mosi  input  1  master-out data.
REQ-008 miso  output  1  slave-out data.
REQ-009 miso_oe  output  1  high while cs low (synchronized), for pad tristate.
REQ-010 loc_addr  input  4  local read address into register bank.
REQ-011 loc_rdata  output  8  combinational bank[loc_addr].
REQ-012 wr_pulse  output  1  one-clk strobe on SPI write commit.
REQ-013 wr_addr  output  4  address of last committed write, held.
REQ-014 wr_data  output  8  data of last committed write, held.
REQ-015 frame_done  output  1  one-clk strobe on completed 16-bit frame.
REQ-016 frame_err  output  1  one-clk strobe on aborted or rejected frame.

Function
REQ-017 Frame SHALL be 16 bits, MSB first: bit0 RW (1=read, 0=write), bits1-7 addr[6:0], bits8-15 data[7:0].
REQ-018 mosi SHALL be sampled on detected sck rising edges; miso SHALL change on detected sck falling edges.
REQ-019 sck, cs, mosi SHALL pass through SYNC_STAGES flops; edges detected from one extra flop.
REQ-020 FSM states IDLE, HDR, DATA, HOLD; reset state IDLE.
REQ-021 IDLE->HDR on synchronized cs falling; bit counter cleared to 0.
REQ-022 HDR: shift 8 rising-edge samples into RW/addr; after 8th -> DATA.
REQ-023 On HDR->DATA with RW=1, tx shift register SHALL load bank[addr[3:0]]; bit7 driven on miso at next falling edge, next bits on following falling edges.
REQ-024 DATA: shift 8 rising-edge samples; after 16th -> HOLD, frame_done pulses once.
REQ-025 Write (RW=0) SHALL commit bank[addr[3:0]] <= data, update wr_addr/wr_data, pulse wr_pulse in the same clk as frame_done.
REQ-026 Read SHALL NOT modify the bank; wr_pulse stays 0.
REQ-027 HOLD: further sck edges ignored until cs rises -> IDLE.
REQ-028 cs rising in HDR or DATA SHALL abort: no commit, frame_err pulses, -> IDLE.
REQ-029 cs high: miso=0, miso_oe=0.
REQ-030 wr_pulse/frame_done SHALL occur within SYNC_STAGES+2 clk of the 16th sck rising edge.
REQ-031 loc_rdata SHALL reflect a write in the clk after wr_pulse.

Reset
REQ-032 rst_n low SHALL force: FSM IDLE, counter 0, all 16 bank bytes 0x00, miso 0, miso_oe 0, wr_pulse 0, wr_addr 0, wr_data 0x00, frame_done 0, frame_err 0, synchronizers to idle (cs=1, sck=0, mosi=0).
REQ-033 Reset mid-frame SHALL discard the frame; first frame after release SHALL begin only on a fresh cs falling edge.

Configuration
REQ-034 Macro SPIS_ADDR_CHECK_EN: defined -> addr[6:4]!=0 is rejected: write not committed, read returns 0x00, frame_err pulses with frame_done at frame end.
REQ-035 Macro not defined -> addr[6:4] ignored; addresses alias onto 16 registers; frame_err only on abort.

Verification
REQ-036 Write 0x05 data 0xA5 (frame 0x05A5) -> wr_pulse once, wr_addr=5, wr_data=0xA5, loc_addr=5 gives 0xA5.
REQ-037 After REQ-036, read addr 5 (header 0x85) -> miso bits 1010_0101 on data phase, bank unchanged, wr_pulse 0.
REQ-038 cs raised after 11 bits of write 0x03/0xFF -> frame_err pulse, bank[3] stays 0x00, next frame decodes normally.
REQ-039 Write addr 0x12 data 0x3C -> with SPIS_ADDR_CHECK_EN: frame_err, bank[2]=0x00; without: bank[2]=0x3C.
REQ-040 rst_n asserted after 9 bits of write 0x07/0x11 -> all outputs at reset values, bank[7]=0x00; 20 extra sck pulses with cs low then cs high -> no strobes.

Source files
------------

// File: rtl/spi_slave_regs.sv
// SPI slave (mode-0 style sampling) fronting a 16 x 8-bit register bank, fully in the clk domain.
// Optional macro SPIS_ADDR_CHECK_EN rejects frames whose addr[6:4] is non-zero.
module spi_slave_regs #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sck,
    input  logic       cs,
    input  logic       mosi,
    output logic       miso,
    output logic       miso_oe,
    input  logic [3:0] loc_addr,
    output logic [7:0] loc_rdata,
    output logic       wr_pulse,
    output logic [3:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       frame_done,
    output logic       frame_err
);

    typedef enum logic [1:0] {IDLE, HDR, DATA, HOLD} state_t;

    logic [SYNC_STAGES-1:0] sck_sync_q, cs_sync_q, mosi_sync_q, vld_q;
    logic                   sck_prev_q, cs_prev_q, armed_q;
    logic                   sck_s, cs_s, mosi_s;
    logic                   sck_rise, sck_fall, cs_fall, cs_rise;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  hdr_q, hdr_d, hdr_full;
    logic [6:0]  rx_q, rx_d;
    logic [7:0]  rx_full;
    logic [7:0]  tx_q, tx_d;
    logic        miso_q, miso_d, miso_oe_q, miso_oe_d;
    logic        wr_pulse_q, wr_pulse_d, frame_done_q, frame_done_d, frame_err_q, frame_err_d;
    logic [3:0]  wr_addr_q, wr_addr_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic        bank_we, rd_ok, wr_ok;
    logic [7:0]  bank_q [16];

    // Input synchronizers plus one edge-detect flop; armed_q blocks a stale cs-low after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync_q  <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            vld_q       <= '0;
            sck_prev_q  <= 1'b0;
            cs_prev_q   <= 1'b1;
            armed_q     <= 1'b0;
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            vld_q       <= {vld_q[SYNC_STAGES-2:0], 1'b1};
            sck_prev_q  <= sck_s;
            cs_prev_q   <= cs_s;
            armed_q     <= armed_q | (vld_q[SYNC_STAGES-1] & cs_s);
        end
    end

    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign cs_s     = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_prev_q;
    assign sck_fall = ~sck_s & sck_prev_q;
    assign cs_fall  = armed_q & cs_prev_q & ~cs_s;
    assign cs_rise  = cs_s & ~cs_prev_q;

    assign hdr_full = {hdr_q[6:0], mosi_s};
    assign rx_full  = {rx_q, mosi_s};

`ifdef SPIS_ADDR_CHECK_EN
    assign rd_ok = (hdr_full[6:4] == 3'b000);
    assign wr_ok = (hdr_q[6:4] == 3'b000);
`else
    assign rd_ok = 1'b1;
    assign wr_ok = 1'b1;
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        hdr_d        = hdr_q;
        rx_d         = rx_q;
        tx_d         = tx_q;
        miso_d       = miso_q;
        wr_pulse_d   = 1'b0;
        frame_done_d = 1'b0;
        frame_err_d  = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        bank_we      = 1'b0;
        miso_oe_d    = armed_q & ~cs_s;
        case (state_q)
            IDLE: begin
                miso_d = 1'b0;
                if (cs_fall) begin
                    state_d = HDR;
                    cnt_d   = 4'd0;
                end
            end
            HDR: begin
                if (cs_rise) begin
                    state_d     = IDLE;
                    frame_err_d = 1'b1;
                end else if (sck_rise) begin
                    hdr_d = hdr_full;
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd7) begin
                        state_d = DATA;
                        tx_d    = (hdr_full[7] && rd_ok) ? bank_q[hdr_full[3:0]] : 8'h00;
                    end
                end
            end
            DATA: begin
                if (cs_rise) begin
                    state_d     = IDLE;
                    frame_err_d = 1'b1;
                end else if (sck_fall) begin
                    miso_d = tx_q[7];
                    tx_d   = {tx_q[6:0], 1'b0};
                end else if (sck_rise) begin
                    rx_d  = rx_full[6:0];
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        state_d      = HOLD;
                        frame_done_d = 1'b1;
                        if (!wr_ok) begin
                            frame_err_d = 1'b1;
                        end else if (!hdr_q[7]) begin
                            bank_we    = 1'b1;
                            wr_pulse_d = 1'b1;
                            wr_addr_d  = hdr_q[3:0];
                            wr_data_d  = rx_full;
                        end
                    end
                end
            end
            HOLD: begin
                if (cs_rise) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (cs_s) miso_d = 1'b0;
    end

    // Control and register bank state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            miso_q       <= 1'b0;
            miso_oe_q    <= 1'b0;
            wr_pulse_q   <= 1'b0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
            wr_addr_q    <= 4'd0;
            wr_data_q    <= 8'h00;
            for (int i = 0; i < 16; i++) bank_q[i] <= 8'h00;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            miso_q       <= miso_d;
            miso_oe_q    <= miso_oe_d;
            wr_pulse_q   <= wr_pulse_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            if (bank_we) bank_q[hdr_q[3:0]] <= rx_full;
        end
    end

    // Shift registers carry data only and need no reset
    always_ff @(posedge clk) begin
        hdr_q <= hdr_d;
        rx_q  <= rx_d;
        tx_q  <= tx_d;
    end

    assign miso       = miso_q;
    assign miso_oe    = miso_oe_q;
    assign loc_rdata  = bank_q[loc_addr];
    assign wr_pulse   = wr_pulse_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign frame_done = frame_done_q;
    assign frame_err  = frame_err_q;

endmodule
